// File: rtl/systolic_skew_feeder_if.sv
// Operand-load and skewed-stream signals between a systolic feeder and its driver.
// The driver (master) writes rows and issues start; the feeder (slave) drives the lanes.
interface systolic_skew_feeder_if #(
    parameter int BITS_AB = 8,
    parameter int DIM     = 8
);
    logic                      WrEn;
    logic [$clog2(DIM)-1:0]    Wrow;
    logic signed [BITS_AB-1:0] Win [DIM];
    logic                      start;
    logic signed [BITS_AB-1:0] Aout [DIM];
    logic                      en_out;
    logic                      busy;
    logic                      done;

    modport master (
        output WrEn, Wrow, Win, start,
        input  Aout, en_out, busy, done
    );

    modport slave (
        input  WrEn, Wrow, Win, start,
        output Aout, en_out, busy, done
    );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Buffers a DIM x DIM operand matrix and streams it into one systolic array edge,
// delaying lane r by r cycles so operands meet on the array diagonal.
module systolic_skew_feeder #(
    parameter int BITS_AB = 8,
    parameter int DIM     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    systolic_skew_feeder_if.slave bus
);
    localparam int CW   = $clog2(2 * DIM);
    localparam int LAST = 2 * DIM - 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                    state;
    logic [CW-1:0]             cnt;
    logic signed [BITS_AB-1:0] m      [DIM][DIM];
    logic signed [BITS_AB-1:0] aout_q [DIM];
    logic signed [BITS_AB-1:0] nxt    [DIM];
    logic [CW-1:0]             nt;
    logic                      en_q;
    logic                      busy_q;
    logic                      done_q;
    logic                      wr_ok;

    // A start in the same IDLE cycle wins over a write, so the stream sees the old matrix.
    assign wr_ok = bus.WrEn && ((state == IDLE && !bus.start) || state == DONE);

    // Lane pattern for the index that will be on the outputs after the next edge.
    // NOTE: every always_comb output gets a default before any condition, so no latch is inferred.
    always_comb begin
        nt = (state == STREAM) ? cnt + 1'b1 : '0;
        for (int r = 0; r < DIM; r++) begin
            nxt[r] = '0;
            for (int k = 0; k < DIM; k++) begin
                if (int'(nt) - r == k) nxt[r] = m[r][k];
            end
        end
    end

    // NOTE: the operand buffer is reset explicitly because it must read as zero after reset;
    // plain storage arrays normally stay out of the reset path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            en_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            for (int r = 0; r < DIM; r++) begin
                aout_q[r] <= '0;
                for (int k = 0; k < DIM; k++) m[r][k] <= '0;
            end
        end else begin
            if (wr_ok) begin
                for (int k = 0; k < DIM; k++) m[bus.Wrow][k] <= bus.Win[k];
            end

            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    cnt    <= '0;
                    if (bus.start) begin
                        state  <= STREAM;
                        en_q   <= 1'b1;
                        busy_q <= 1'b1;
                        aout_q <= nxt;
                    end
                end
                STREAM: begin
                    if (cnt == CW'(LAST)) begin
                        state  <= DONE;
                        cnt    <= '0;
                        en_q   <= 1'b0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        for (int r = 0; r < DIM; r++) aout_q[r] <= '0;
                    end else begin
                        cnt    <= cnt + 1'b1;
                        aout_q <= nxt;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    en_q   <= 1'b0;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    for (int r = 0; r < DIM; r++) aout_q[r] <= '0;
                end
            endcase
        end
    end

    assign bus.Aout   = aout_q;
    assign bus.en_out = en_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Randomized bench for systolic_skew_feeder; expected lanes come from a matrix model
// and the skew rule lane r at index t = M[r][t-r].
module tb_systolic_skew_feeder;
    localparam int B    = 8;
    localparam int DIM  = 8;
    localparam int W    = B * DIM;
    localparam int LAST = 2 * DIM - 2;

    typedef logic signed [B-1:0] row_t [DIM];

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    systolic_skew_feeder_if #(.BITS_AB(B), .DIM(DIM)) bus ();

    systolic_skew_feeder #(.BITS_AB(B), .DIM(DIM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    logic signed [B-1:0] mdl [DIM][DIM];
    logic [W-1:0]        cap [2*DIM-1];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] dut_lanes();
        logic [W-1:0] v;
        for (int r = 0; r < DIM; r++) v[r*B +: B] = bus.Aout[r];
        return v;
    endfunction

    function automatic logic [W-1:0] exp_lanes(input int t);
        logic [W-1:0] v = '0;
        for (int r = 0; r < DIM; r++) begin
            if (t - r >= 0 && t - r < DIM) v[r*B +: B] = mdl[r][t-r];
        end
        return v;
    endfunction

    task automatic write_row(input int r, input row_t vals);
        bus.WrEn = 1'b1;
        bus.Wrow = r[$clog2(DIM)-1:0];
        for (int k = 0; k < DIM; k++) bus.Win[k] = vals[k];
        cycle();
        bus.WrEn = 1'b0;
        for (int k = 0; k < DIM; k++) mdl[r][k] = vals[k];
    endtask

    // Streams from IDLE; optional junk write alongside start or a write+start during index inj_t.
    task automatic run_stream(input int sid, input int inj_t, input bit wr_with_start);
        bus.start = 1'b1;
        if (wr_with_start) begin
            bus.WrEn = 1'b1;
            bus.Wrow = '0;
            for (int k = 0; k < DIM; k++) bus.Win[k] = 8'sd9;
        end
        cycle();
        bus.start = 1'b0;
        bus.WrEn  = 1'b0;
        for (int t = 0; t <= LAST; t++) begin
            cap[t] = dut_lanes();
            check($sformatf("s%0d_t%0d_en", sid, t), W'(bus.en_out), W'(1));
            check($sformatf("s%0d_t%0d_busy", sid, t), W'(bus.busy), W'(1));
            check($sformatf("s%0d_t%0d_done", sid, t), W'(bus.done), W'(0));
            check($sformatf("s%0d_t%0d_lanes", sid, t), cap[t], exp_lanes(t));
            if (t == inj_t) begin
                bus.WrEn  = 1'b1;
                bus.Wrow  = 3'd2;
                for (int k = 0; k < DIM; k++) bus.Win[k] = -8'sd1;
                bus.start = 1'b1;
            end
            cycle();
            bus.WrEn  = 1'b0;
            bus.start = 1'b0;
        end
        check($sformatf("s%0d_end_en", sid), W'(bus.en_out), W'(0));
        check($sformatf("s%0d_end_busy", sid), W'(bus.busy), W'(0));
        check($sformatf("s%0d_end_done", sid), W'(bus.done), W'(1));
        check($sformatf("s%0d_end_lanes", sid), dut_lanes(), '0);
        cycle();
        check($sformatf("s%0d_post_done", sid), W'(bus.done), W'(0));
    endtask

    initial begin
        row_t row;
        int   len, gap, donec;

        rst_n     = 1'b0;
        bus.WrEn  = 1'b0;
        bus.Wrow  = '0;
        bus.start = 1'b0;
        for (int k = 0; k < DIM; k++) bus.Win[k] = '0;
        for (int r = 0; r < DIM; r++) for (int k = 0; k < DIM; k++) mdl[r][k] = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_lanes", dut_lanes(), '0);
        check("rst_en", W'(bus.en_out), W'(0));
        check("rst_busy", W'(bus.busy), W'(0));
        check("rst_done", W'(bus.done), W'(0));
        rst_n = 1'b1;
        cycle();

        // Full skew: M[r][c] = r*8+c+1
        for (int r = 0; r < DIM; r++) begin
            for (int k = 0; k < DIM; k++) row[k] = B'(r * 8 + k + 1);
            write_row(r, row);
        end
        run_stream(0, -1, 1'b0);
        check("skew_t0", cap[0], 64'h0000_0000_0000_0001);
        check("skew_t3", cap[3], 64'h0000_0000_1912_0B04);
        check("skew_t14", cap[14], 64'h4000_0000_0000_0000);

        // Write + start during stream are ignored; next stream keeps row 2
        run_stream(1, 4, 1'b0);
        run_stream(2, -1, 1'b0);

        // Write with start in IDLE is dropped, twice over
        run_stream(3, -1, 1'b1);
        run_stream(4, -1, 1'b0);
        check("wrstart_old_m00", W'(cap[0][7:0]), W'(8'd1));

        // Signed passthrough
        for (int r = 0; r < DIM; r++) begin
            for (int k = 0; k < DIM; k++) row[k] = '0;
            if (r == 0) row[0] = -8'sd128;
            if (r == 7) row[7] = 8'sd127;
            write_row(r, row);
        end
        run_stream(5, -1, 1'b0);
        check("sign_l0_t0", W'(cap[0][7:0]), W'(8'h80));
        check("sign_l7_t14", W'(cap[14][63:56]), W'(8'h7F));

        // Randomized rounds, including repeated writes to the same row
        for (int it = 0; it < 4; it++) begin
            int nw = $urandom_range(3, 12);
            for (int n = 0; n < nw; n++) begin
                for (int k = 0; k < DIM; k++) row[k] = B'($urandom);
                write_row($urandom_range(0, DIM - 1), row);
            end
            run_stream(10 + it, -1, 1'b0);
        end

        // Back-to-back with start held high
        bus.start = 1'b1;
        cycle();
        for (int s = 0; s < 3; s++) begin
            len = 0;
            while (bus.en_out && len < 40) begin
                len++;
                cycle();
            end
            check($sformatf("b2b_len%0d", s), W'(len), W'(2 * DIM - 1));
            if (s < 2) begin
                gap   = 0;
                donec = 0;
                while (!bus.en_out && gap < 40) begin
                    gap++;
                    donec += int'(bus.done);
                    cycle();
                end
                check($sformatf("b2b_gap%0d", s), W'(gap), W'(2));
                check($sformatf("b2b_done%0d", s), W'(donec), W'(1));
            end
        end
        bus.start = 1'b0;
        cycle();
        cycle();

        // Reset mid-stream at t=5
        for (int r = 0; r < DIM; r++) begin
            for (int k = 0; k < DIM; k++) row[k] = B'($urandom_range(1, 100));
            write_row(r, row);
        end
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        repeat (5) cycle();
        check("mid_t5_lanes", dut_lanes(), exp_lanes(5));
        #2 rst_n = 1'b0;
        #1;
        check("arst_lanes", dut_lanes(), '0);
        check("arst_en", W'(bus.en_out), W'(0));
        check("arst_busy", W'(bus.busy), W'(0));
        check("arst_done", W'(bus.done), W'(0));
        for (int i = 0; i < 3; i++) begin
            cycle();
            check($sformatf("arst_hold_done%0d", i), W'(bus.done), W'(0));
        end
        rst_n = 1'b1;
        for (int r = 0; r < DIM; r++) for (int k = 0; k < DIM; k++) mdl[r][k] = '0;
        cycle();
        check("after_rst_done", W'(bus.done), W'(0));
        run_stream(20, -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
